// File: rtl/rom_loader_if.sv
// Byte-stream loader bus: incoming byte handshake, program memory write port
// and core-control status, bundled for rom_loader and its environment.
interface rom_loader_if #(
   parameter int WORD_WIDTH = 24,
   parameter int ADDR_BITS  = 8
);
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  wr_en;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [WORD_WIDTH-1:0] wr_data;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;

   // The loader consumes the byte stream and drives memory writes and status.
   modport master (
      input  byte_in, byte_valid,
      output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
   );
endinterface

// File: rtl/rom_loader.sv
// Serial program loader: sync 0xA5, length byte, then MSB-first packed words
// written to program memory. Define ROM_LOADER_CHECKSUM_EN to add a trailing checksum byte.
module rom_loader #(
   parameter int WORD_WIDTH = 24,
   parameter int ADDR_BITS  = 8
) (
   input  logic         clk_in,
   input  logic         rst_in,
   rom_loader_if.master bus
);

   localparam int              BPW       = WORD_WIDTH / 8;
   localparam int              BCW       = $clog2(BPW);
   localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BPW - 1);
   localparam logic [7:0]      SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK  = 3'd3,
`endif
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t                 state;
   logic [BCW-1:0]         byte_cnt;
   logic [8:0]             words_left;
   logic [WORD_WIDTH-9:0]  acc;
   logic [WORD_WIDTH-1:0]  packed_word;
   logic                   take;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0]             sum;
`endif

   assign take        = bus.byte_valid & bus.byte_ready;
   assign packed_word = {acc, bus.byte_in};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         bus.byte_ready <= 1'b1;
         bus.wr_en      <= 1'b0;
         bus.wr_addr    <= '0;
         bus.wr_data    <= '0;
         bus.cpu_hold   <= 1'b0;
         bus.done       <= 1'b0;
         bus.error      <= 1'b0;
         byte_cnt       <= '0;
         words_left     <= '0;
         acc            <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum            <= '0;
`endif
      end else begin
         bus.wr_en <= 1'b0;
         bus.done  <= 1'b0;
         // Address advances the cycle after each strobe; LEN below overrides it.
         if (bus.wr_en)
            bus.wr_addr <= bus.wr_addr + 1'b1;

         case (state)
            IDLE: begin
               if (take && bus.byte_in == SYNC_BYTE) begin
                  state        <= LEN;
                  bus.cpu_hold <= 1'b1;
               end
            end

            LEN: begin
               if (take) begin
                  words_left  <= (bus.byte_in == 8'd0) ? 9'd256 : {1'b0, bus.byte_in};
                  bus.wr_addr <= '0;
                  byte_cnt    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                  sum         <= '0;
`endif
                  state       <= DATA;
               end
            end

            DATA: begin
               if (take) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                  sum <= sum + bus.byte_in;
`endif
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt    <= '0;
                     bus.wr_data <= packed_word;
                     bus.wr_en   <= 1'b1;
                     words_left  <= words_left - 9'd1;
                     if (words_left == 9'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state <= CHK;
`else
                        state          <= DONE;
                        bus.done       <= 1'b1;
                        bus.cpu_hold   <= 1'b0;
                        bus.byte_ready <= 1'b0;
`endif
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     acc      <= packed_word[WORD_WIDTH-9:0];
                  end
               end
            end

`ifdef ROM_LOADER_CHECKSUM_EN
            CHK: begin
               if (take) begin
                  if (bus.byte_in == sum) begin
                     state          <= DONE;
                     bus.done       <= 1'b1;
                     bus.cpu_hold   <= 1'b0;
                     bus.byte_ready <= 1'b0;
                  end else begin
                     state     <= ERR;
                     bus.error <= 1'b1;
                  end
               end
            end
`endif

            DONE: begin
               state          <= IDLE;
               bus.byte_ready <= 1'b1;
            end

            // The core stays held until a fresh sync byte restarts the load.
            ERR: begin
               if (take && bus.byte_in == SYNC_BYTE) begin
                  bus.error <= 1'b0;
                  state     <= LEN;
               end
            end

            default: begin
               state          <= IDLE;
               bus.byte_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
